ldpc_enc_core: RTL

LDPC_ENC_CORE -- requirements
Module: ldpc_enc_core

---
 rtl/ldpc_enc_core.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ldpc_enc_core.sv
// Systematic QC-LDPC encoder core with staircase parity part.
// Info blocks pass straight through while per-row accumulators (lambda) build
// up the circulant products; parity blocks are then emitted as a running XOR.
module ldpc_enc_core #(
   parameter int unsigned D     = 96,
   parameter int unsigned R     = 24,
   parameter int unsigned C     = 12,
   parameter int unsigned mtx_w = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [C*(R-C)*mtx_w-1:0]   mtx,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [D-1:0]               in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [D-1:0]               out_data,
   output logic                       out_last,
   output logic                       busy
);

   localparam int unsigned K  = R - C;
   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
   localparam int unsigned BW = (KW > CW) ? KW : CW;

   typedef enum logic {
      ST_ACCUM  = 1'b0,
      ST_PARITY = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   blk_q, blk_d;
   logic [D-1:0]    p_prev_q, p_prev_d;
   logic [D-1:0]    lambda_q [C];
   logic [D-1:0]    lambda_d [C];

   logic [mtx_w-1:0] ent     [C][K];
   logic [D-1:0]     contrib_c [C];
   logic [D-1:0]     parity_c;
   logic [KW-1:0]    kidx;
   logic [CW-1:0]    cidx;
   logic             blk_info_last;
   logic             blk_par_last;

   // Circulant product: result[k] = u[(k+s) mod D]; shifts >= D are null blocks.
   function automatic logic [D-1:0] circ(input logic [D-1:0] u, input logic [mtx_w-1:0] s);
      logic [2*D-1:0] dbl;
      dbl  = {u, u};
      circ = '0;
      if (32'(s) < D) begin
         circ = D'(dbl >> s);
      end
   endfunction

   // Unpack the flat shift-entry matrix into (row, column) entries.
   for (genvar gi = 0; gi < C; gi++) begin : g_row
      for (genvar gj = 0; gj < K; gj++) begin : g_col
         assign ent[gi][gj] = mtx[(gi*K+gj)*mtx_w +: mtx_w];
      end
   end

   assign kidx          = KW'(blk_q);
   assign cidx          = CW'(blk_q);
   assign blk_info_last = (blk_q == BW'(K - 1));
   assign blk_par_last  = (blk_q == BW'(C - 1));
   assign parity_c      = p_prev_q ^ lambda_q[cidx];
   assign busy          = (state_q == ST_PARITY) || (blk_q != '0);

   // Per-row contribution of the info block currently at the input.
   always_comb begin
      for (int i = 0; i < C; i++) begin
         contrib_c[i] = circ(in_data, ent[i][kidx]);
      end
   end

   // Next-state, accumulator update and handshake outputs.
   always_comb begin
      state_d   = state_q;
      blk_d     = blk_q;
      p_prev_d  = p_prev_q;
      for (int i = 0; i < C; i++) begin
         lambda_d[i] = lambda_q[i];
      end
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;

      unique case (state_q)
         ST_ACCUM: begin
            in_ready  = out_ready;
            out_valid = in_valid;
            out_data  = in_data;
            if (in_valid && out_ready) begin
               for (int i = 0; i < C; i++) begin
                  lambda_d[i] = lambda_q[i] ^ contrib_c[i];
               end
               if (blk_info_last) begin
                  state_d  = ST_PARITY;
                  blk_d    = '0;
                  p_prev_d = '0;
               end else begin
                  blk_d = blk_q + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            out_valid = 1'b1;
            out_data  = parity_c;
            out_last  = blk_par_last;
            if (out_ready) begin
               if (blk_par_last) begin
                  state_d  = ST_ACCUM;
                  blk_d    = '0;
                  p_prev_d = '0;
                  for (int i = 0; i < C; i++) begin
                     lambda_d[i] = '0;
                  end
               end else begin
                  p_prev_d = parity_c;
                  blk_d    = blk_q + BW'(1);
               end
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   // State, counter and accumulator registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_ACCUM;
         blk_q    <= '0;
         p_prev_q <= '0;
         for (int i = 0; i < C; i++) begin
            lambda_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         blk_q    <= blk_d;
         p_prev_q <= p_prev_d;
         for (int i = 0; i < C; i++) begin
            lambda_q[i] <= lambda_d[i];
         end
      end
   end

endmodule
